readout_frame_sched: RTL

Frame-level scheduler that sequences the row readout engine. It issues the readout trigger, holds it until the engine acknowledges with re_busy, waits for the frame to finish, and inserts a programmable inter-frame gap. It runs N frames or runs continuously, with clean stop and a watchdog timeout. It sits between the host/register bank and the readout engine, in the CLK domain.

---
 rtl/readout_sched_pkg.sv | 16 +
 rtl/sched_timer.sv | 37 +++
 rtl/readout_frame_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/readout_sched_pkg.sv
// Shared definitions for the readout frame scheduler: state encoding and
// default counter widths.
package readout_sched_pkg;

    localparam int FCNT_W_DEF = 16;
    localparam int TMR_W_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        TRIG = 3'd2,
        BUSY = 3'd3,
        GAP  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter used for both the inter-frame gap and the per-frame
// watchdog. Reports expiry once the count has reached one (or was loaded as 0).
module sched_timer #(
    parameter int TMR_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Load has priority; the count parks at zero rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(TMR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q <= {{(TMR_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/readout_frame_sched.sv
// Frame-level scheduler driving the row readout engine (trigger/ack, gap, watchdog).
// Optional macro READOUT_SCHED_EXT_SYNC_EN adds the ext_sync frame-start qualifier.
module readout_frame_sched
    import readout_sched_pkg::*;
#(
    parameter int FCNT_W = FCNT_W_DEF,
    parameter int TMR_W  = TMR_W_DEF
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [FCNT_W-1:0] num_frames,
    input  logic [TMR_W-1:0]  gap_cycles,
    input  logic [TMR_W-1:0]  timeout_cycles,
    input  logic              clr_err,
    input  logic              re_busy,
`ifdef READOUT_SCHED_EXT_SYNC_EN
    input  logic              ext_sync,
`endif
    output logic              trigger,
    output logic              sched_busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              timeout_err
);

    sched_state_e      state_q, state_d;
    logic              trigger_q, trigger_d;
    logic              frameDone_q, frameDone_d;
    logic [FCNT_W-1:0] frameCnt_q, frameCnt_d;
    logic              timeoutErr_q, timeoutErr_d;
    logic              stopPend_q, stopPend_d;
    logic              contCfg_q, contCfg_d;
    logic [FCNT_W-1:0] numCfg_q, numCfg_d;
    logic [TMR_W-1:0]  gapCfg_q, gapCfg_d;
    logic [TMR_W-1:0]  tmoCfg_q, tmoCfg_d;

    logic              gapLoad, gapExpired;
    logic              wdLoad, wdExpired, wdFire;
    logic              armGo, gapGo;
    logic [FCNT_W-1:0] cntInc;

    sched_timer #(.TMR_W(TMR_W)) u_gap_timer (
        .clk_i      (CLK),
        .rst_ni     (rst_n),
        .load_i     (gapLoad),
        .load_val_i (gapCfg_q),
        .en_i       (state_q == GAP),
        .expired_o  (gapExpired)
    );

    sched_timer #(.TMR_W(TMR_W)) u_wd_timer (
        .clk_i      (CLK),
        .rst_ni     (rst_n),
        .load_i     (wdLoad),
        .load_val_i (tmoCfg_q),
        .en_i       ((state_q == TRIG) || (state_q == BUSY)),
        .expired_o  (wdExpired)
    );

    // A zero timeout disables the watchdog entirely.
    assign wdFire = (tmoCfg_q != '0) && ((state_q == TRIG) || (state_q == BUSY)) && wdExpired;

`ifdef READOUT_SCHED_EXT_SYNC_EN
    logic first_q;

    // Only the first frame of a run waits for ext_sync in ARM; later frames
    // are already aligned by the gap exit.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
        end else if ((state_q == IDLE) && (state_d == ARM)) begin
            first_q <= 1'b1;
        end else if ((state_q == ARM) && (state_d == TRIG)) begin
            first_q <= 1'b0;
        end
    end

    assign armGo = !re_busy && (!first_q || ext_sync);
    assign gapGo = gapExpired && ext_sync;
`else
    assign armGo = !re_busy;
    assign gapGo = gapExpired;
`endif

    // Next-state and registered-output logic for the frame sequence.
    always_comb begin
        state_d      = state_q;
        trigger_d    = 1'b0;
        frameDone_d  = 1'b0;
        frameCnt_d   = frameCnt_q;
        stopPend_d   = stopPend_q;
        contCfg_d    = contCfg_q;
        numCfg_d     = numCfg_q;
        gapCfg_d     = gapCfg_q;
        tmoCfg_d     = tmoCfg_q;
        timeoutErr_d = timeoutErr_q;
        gapLoad      = 1'b0;
        wdLoad       = 1'b0;
        cntInc       = frameCnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};

        if (clr_err) begin
            timeoutErr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop && (continuous || (num_frames != '0))) begin
                    contCfg_d  = continuous;
                    numCfg_d   = num_frames;
                    gapCfg_d   = gap_cycles;
                    tmoCfg_d   = timeout_cycles;
                    frameCnt_d = '0;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (armGo) begin
                    state_d   = TRIG;
                    trigger_d = 1'b1;
                    wdLoad    = 1'b1;
                end
            end
            TRIG: begin
                if (wdFire) begin
                    timeoutErr_d = 1'b1;
                    state_d      = IDLE;
                end else if (stop) begin
                    state_d = IDLE;
                end else if (re_busy) begin
                    state_d = BUSY;
                end else begin
                    trigger_d = 1'b1;
                end
            end
            BUSY: begin
                // A frame that completes on the edge the watchdog would fire is kept.
                if (!re_busy) begin
                    frameDone_d = 1'b1;
                    frameCnt_d  = cntInc;
                    if (stopPend_q || stop || (!contCfg_q && (cntInc == numCfg_q))) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gapLoad = 1'b1;
                    end
                end else if (wdFire) begin
                    timeoutErr_d = 1'b1;
                    state_d      = IDLE;
                end else if (stop) begin
                    stopPend_d = 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (gapGo) begin
                    state_d = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            stopPend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            trigger_q    <= 1'b0;
            frameDone_q  <= 1'b0;
            frameCnt_q   <= '0;
            timeoutErr_q <= 1'b0;
            stopPend_q   <= 1'b0;
            contCfg_q    <= 1'b0;
            numCfg_q     <= '0;
            gapCfg_q     <= '0;
            tmoCfg_q     <= '0;
        end else begin
            state_q      <= state_d;
            trigger_q    <= trigger_d;
            frameDone_q  <= frameDone_d;
            frameCnt_q   <= frameCnt_d;
            timeoutErr_q <= timeoutErr_d;
            stopPend_q   <= stopPend_d;
            contCfg_q    <= contCfg_d;
            numCfg_q     <= numCfg_d;
            gapCfg_q     <= gapCfg_d;
            tmoCfg_q     <= tmoCfg_d;
        end
    end

    assign trigger     = trigger_q;
    assign sched_busy  = (state_q != IDLE);
    assign frame_done  = frameDone_q;
    assign frame_cnt   = frameCnt_q;
    assign timeout_err = timeoutErr_q;

endmodule
